// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul feed controller: default geometry,
// dimension port width, FSM state encoding and a dimension legality helper.
package matmul_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BUS_WIDTH_DEF  = 64;
  localparam int MAX_DIM_DEF    = BUS_WIDTH_DEF / DATA_WIDTH_DEF;

  // Dimension inputs are 2 bits wide; legal values are 1..MAX_DIM.
  localparam int DIM_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A dimension is usable when it is non-zero and fits the array side.
  function automatic logic dim_legal(input logic [DIM_W-1:0] d, input int max_dim);
    return (d != '0) && (int'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/matmul_feed_ctrl.sv
// Purpose: sequences one A*B multiplication into a systolic PE grid (skewed left/top edge feeds + clear).
// Latency: start sampled at edge e0 -> done_o high in the cycle after edge e0+K+N+M.
// Backpressure: none; start_i is only honoured in IDLE and ignored while busy_o is high.
module matmul_feed_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  input  logic [DIM_W-1:0]                      n_i,
  input  logic [DIM_W-1:0]                      k_i,
  input  logic [DIM_W-1:0]                      m_i,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] operand_a_i,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] operand_b_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0]         a_edge_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0]         b_edge_o,
  output logic                                  pe_clear_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  err_o
);

  localparam int OPW = MAX_DIM * MAX_DIM * DATA_WIDTH;
  localparam int EW  = MAX_DIM * DATA_WIDTH;
  // Wide enough for the largest final step 3*MAX_DIM-3.
  localparam int TW  = $clog2(3 * MAX_DIM);

  state_t           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [DIM_W-1:0] n_q, k_q, m_q;
  logic [OPW-1:0]   a_q, b_q;
  logic             capture;

  logic [EW-1:0]    a_edge_q, a_edge_d;
  logic [EW-1:0]    b_edge_q, b_edge_d;
  logic             pe_clear_q, pe_clear_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             dims_ok;
  logic [TW-1:0]    t_last;

  assign dims_ok = dim_legal(n_i, MAX_DIM) && dim_legal(k_i, MAX_DIM) && dim_legal(m_i, MAX_DIM);

  // Last feed step K+N+M-3, taken from the captured dimensions only.
  assign t_last = TW'(k_q) + TW'(n_q) + TW'(m_q) - TW'(3);

  // Next-state and next-output logic; outputs are derived from the next state so they
  // land in the output registers aligned with the state they belong to.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    capture    = 1'b0;
    err_d      = 1'b0;
    a_edge_d   = '0;
    b_edge_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (dims_ok) begin
            state_d = ST_LOAD;
            capture = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_FEED;
        t_d     = '0;
      end
      ST_FEED: begin
        if (t_q == t_last) begin
          state_d = ST_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    pe_clear_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);

    // Skewed feed: row r sees A[r][c] at step r+c, column j sees B[c][j] at step c+j.
    if (state_d == ST_FEED) begin
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int c = 0; c < MAX_DIM; c++) begin
          if (r < int'(n_q) && c < int'(k_q) && int'(t_d) == r + c) begin
            a_edge_d[r*DATA_WIDTH +: DATA_WIDTH] = a_q[(r*MAX_DIM + c)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      for (int j = 0; j < MAX_DIM; j++) begin
        for (int c = 0; c < MAX_DIM; c++) begin
          if (j < int'(m_q) && c < int'(k_q) && int'(t_d) == c + j) begin
            b_edge_d[j*DATA_WIDTH +: DATA_WIDTH] = b_q[(c*MAX_DIM + j)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // State, step counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      a_edge_q   <= '0;
      b_edge_q   <= '0;
      pe_clear_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      a_edge_q   <= a_edge_d;
      b_edge_q   <= b_edge_d;
      pe_clear_q <= pe_clear_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Operand and dimension capture on an accepted start; held for the whole run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q <= '0;
      k_q <= '0;
      m_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (capture) begin
      n_q <= n_i;
      k_q <= k_i;
      m_q <= m_i;
      a_q <= operand_a_i;
      b_q <= operand_b_i;
    end
  end

  assign a_edge_o   = a_edge_q;
  assign b_edge_o   = b_edge_q;
  assign pe_clear_o = pe_clear_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_matmul_feed_ctrl.sv
// Bench for matmul_feed_ctrl at MAX_DIM=2, DATA_WIDTH=32 with a behavioural PE grid attached.
// Edge feeds are compared against per-row/column skewed streams; C against a plain matrix product.
module tb_matmul_feed_ctrl;

  localparam int DW  = 32;
  localparam int MD  = 2;
  localparam int OPW = MD * MD * DW;
  localparam int EW  = MD * DW;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b1;
  logic           start_i = 1'b0;
  logic [1:0]     n_i = '0, k_i = '0, m_i = '0;
  logic [OPW-1:0] operand_a_i = '0, operand_b_i = '0;
  logic [EW-1:0]  a_edge_o, b_edge_o;
  logic           pe_clear_o, busy_o, done_o, err_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] am[MD][MD];
  logic [31:0] bm[MD][MD];

  int bad_n[3] = '{2, 3, 1};
  int bad_k[3] = '{0, 1, 2};
  int bad_m[3] = '{2, 1, 0};

  matmul_feed_ctrl #(.DATA_WIDTH(DW), .BUS_WIDTH(64), .MAX_DIM(MD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .n_i(n_i), .k_i(k_i), .m_i(m_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .a_edge_o(a_edge_o), .b_edge_o(b_edge_o),
    .pe_clear_o(pe_clear_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output-stationary PE grid: a moves right, b moves down, each PE accumulates a*b.
  logic [31:0] g_a[MD][MD], g_b[MD][MD], g_acc[MD][MD];
  logic [31:0] g_ain, g_bin;
  always @(negedge clk_i) begin
    for (int i = 0; i < MD; i++) begin
      for (int j = 0; j < MD; j++) begin
        if (pe_clear_o) begin
          g_a[i][j]   <= '0;
          g_b[i][j]   <= '0;
          g_acc[i][j] <= '0;
        end else begin
          if (j == 0) g_ain = a_edge_o[i*DW +: DW];
          else        g_ain = g_a[i][j-1];
          if (i == 0) g_bin = b_edge_o[j*DW +: DW];
          else        g_bin = g_b[i-1][j];
          g_a[i][j]   <= g_ain;
          g_b[i][j]   <= g_bin;
          g_acc[i][j] <= g_acc[i][j] + g_ain * g_bin;
        end
      end
    end
  end

  // Row r of A enters the array delayed by r cycles, then its K elements in order.
  function automatic logic [31:0] a_stream(input int row, input int n, input int k, input int t);
    logic [31:0] q[$];
    if (row < n) begin
      repeat (row) q.push_back(32'd0);
      for (int x = 0; x < k; x++) q.push_back(am[row][x]);
    end
    return (t < q.size()) ? q[t] : 32'd0;
  endfunction

  // Column j of B enters delayed by j cycles, then its K elements top to bottom.
  function automatic logic [31:0] b_stream(input int col, input int m, input int k, input int t);
    logic [31:0] q[$];
    if (col < m) begin
      repeat (col) q.push_back(32'd0);
      for (int x = 0; x < k; x++) q.push_back(bm[x][col]);
    end
    return (t < q.size()) ? q[t] : 32'd0;
  endfunction

  task automatic pack_ops();
    for (int r = 0; r < MD; r++) begin
      for (int c = 0; c < MD; c++) begin
        operand_a_i[(r*MD + c)*DW +: DW] = am[r][c];
        operand_b_i[(r*MD + c)*DW +: DW] = bm[r][c];
      end
    end
  endtask

  task automatic randomize_mats();
    for (int r = 0; r < MD; r++) begin
      for (int c = 0; c < MD; c++) begin
        am[r][c] = 32'($urandom_range(0, 255));
        bm[r][c] = 32'($urandom_range(0, 255));
      end
    end
  endtask

  // One full run from start through the IDLE cycle after DONE, checking every cycle.
  // With spam set, start_i toggles and all data inputs are scrambled while feeding.
  task automatic do_run(input int n, input int k, input int m, input bit spam);
    int total, tl, dones;
    logic [EW-1:0] ea, eb;
    logic [31:0] ec;
    total = n + k + m;
    tl    = total - 3;
    dones = 0;
    pack_ops();
    n_i = 2'(n); k_i = 2'(k); m_i = 2'(m);
    start_i = 1'b1;
    @(posedge clk_i);
    for (int c = 0; c <= total + 1; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (spam && c >= 1 && c <= tl + 1) begin
        start_i     = 1'($urandom_range(0, 1));
        operand_a_i = {$urandom, $urandom, $urandom, $urandom};
        operand_b_i = {$urandom, $urandom, $urandom, $urandom};
        n_i = 2'($urandom_range(0, 3));
        k_i = 2'($urandom_range(0, 3));
        m_i = 2'($urandom_range(0, 3));
      end
      #1;
      if (done_o === 1'b1) dones++;
      checks++;
      if (pe_clear_o !== 1'(c == 0)) begin
        errors++; $display("FAIL pe_clear cyc=%0d got=%b exp=%b", c, pe_clear_o, c == 0);
      end
      checks++;
      if (busy_o !== 1'(c <= total)) begin
        errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy_o, c <= total);
      end
      checks++;
      if (done_o !== 1'(c == total)) begin
        errors++; $display("FAIL done cyc=%0d got=%b exp=%b", c, done_o, c == total);
      end
      checks++;
      if (err_o !== 1'b0) begin
        errors++; $display("FAIL err_in_run cyc=%0d got=%b exp=0", c, err_o);
      end
      ea = '0;
      eb = '0;
      if (c >= 1 && c <= tl + 1) begin
        for (int i = 0; i < MD; i++) begin
          ea[i*DW +: DW] = a_stream(i, n, k, c - 1);
          eb[i*DW +: DW] = b_stream(i, m, k, c - 1);
        end
      end
      checks++;
      if (a_edge_o !== ea) begin
        errors++; $display("FAIL a_edge cyc=%0d got=%h exp=%h", c, a_edge_o, ea);
      end
      checks++;
      if (b_edge_o !== eb) begin
        errors++; $display("FAIL b_edge cyc=%0d got=%h exp=%h", c, b_edge_o, eb);
      end
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL done_count got=%0d exp=1", dones);
    end
    for (int i = 0; i < MD; i++) begin
      for (int j = 0; j < MD; j++) begin
        ec = '0;
        if (i < n && j < m) begin
          for (int x = 0; x < k; x++) ec = ec + am[i][x] * bm[x][j];
        end
        checks++;
        if (g_acc[i][j] !== ec) begin
          errors++; $display("FAIL c_matrix[%0d][%0d] n=%0d k=%0d m=%0d got=%0d exp=%0d", i, j, n, k, m, g_acc[i][j], ec);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, pe_clear_o} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {busy_o, done_o, err_o, pe_clear_o});
    end
    checks++;
    if ({a_edge_o, b_edge_o} !== '0) begin
      errors++; $display("FAIL reset_edges got=%h exp=0", {a_edge_o, b_edge_o});
    end
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    checks++;
    if ({busy_o, done_o, err_o, pe_clear_o} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset got=%b exp=0000", {busy_o, done_o, err_o, pe_clear_o});
    end
  endtask

  task automatic test_directed();
    am = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}};
    bm = '{'{32'd5, 32'd6}, '{32'd7, 32'd8}};
    do_run(2, 2, 2, 1'b0);
    checks++;
    if ({g_acc[0][0], g_acc[0][1], g_acc[1][0], g_acc[1][1]} !== {32'd19, 32'd22, 32'd43, 32'd50}) begin
      errors++; $display("FAIL c_2x2 got=%0d,%0d,%0d,%0d exp=19,22,43,50", g_acc[0][0], g_acc[0][1], g_acc[1][0], g_acc[1][1]);
    end
    randomize_mats();
    am[0][0] = 32'd7;
    bm[0][0] = 32'd9;
    do_run(1, 1, 1, 1'b0);
    checks++;
    if ({g_acc[0][0], g_acc[0][1], g_acc[1][0], g_acc[1][1]} !== {32'd63, 32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL c_1x1 got=%0d,%0d,%0d,%0d exp=63,0,0,0", g_acc[0][0], g_acc[0][1], g_acc[1][0], g_acc[1][1]);
    end
    randomize_mats();
    am[0][0] = 32'd2; am[1][0] = 32'd3;
    bm[0][0] = 32'd4; bm[0][1] = 32'd5;
    do_run(2, 1, 2, 1'b0);
    checks++;
    if ({g_acc[0][0], g_acc[0][1], g_acc[1][0], g_acc[1][1]} !== {32'd8, 32'd10, 32'd12, 32'd15}) begin
      errors++; $display("FAIL c_outer got=%0d,%0d,%0d,%0d exp=8,10,12,15", g_acc[0][0], g_acc[0][1], g_acc[1][0], g_acc[1][1]);
    end
  endtask

  task automatic test_err();
    for (int x = 0; x < 3; x++) begin
      randomize_mats();
      pack_ops();
      n_i = 2'(bad_n[x]); k_i = 2'(bad_k[x]); m_i = 2'(bad_m[x]);
      start_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      #1;
      checks++;
      if ({err_o, busy_o, pe_clear_o} !== 3'b100) begin
        errors++; $display("FAIL err_pulse case=%0d got err/busy/clr=%b exp=100", x, {err_o, busy_o, pe_clear_o});
      end
      @(negedge clk_i);
      #1;
      checks++;
      if ({err_o, busy_o, pe_clear_o} !== 3'b000) begin
        errors++; $display("FAIL err_after case=%0d got err/busy/clr=%b exp=000", x, {err_o, busy_o, pe_clear_o});
      end
    end
  endtask

  task automatic test_ignore_start();
    randomize_mats();
    do_run(2, 2, 2, 1'b1);
    randomize_mats();
    do_run(2, 1, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    randomize_mats();
    do_run(2, 2, 2, 1'b0);
    randomize_mats();
    do_run(1, 2, 2, 1'b0);
    randomize_mats();
    do_run(2, 2, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      randomize_mats();
      do_run($urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_feed();
    int dones;
    dones = 0;
    am = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}};
    bm = '{'{32'd5, 32'd6}, '{32'd7, 32'd8}};
    pack_ops();
    n_i = 2'd2; k_i = 2'd2; m_i = 2'd2;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, pe_clear_o} !== 4'b0 || {a_edge_o, b_edge_o} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got flags=%b edges=%h exp=0", {busy_o, done_o, err_o, pe_clear_o}, {a_edge_o, b_edge_o});
    end
    repeat (3) begin
      @(negedge clk_i);
      if (done_o === 1'b1) dones++;
    end
    rst_ni = 1'b1;
    repeat (6) begin
      @(negedge clk_i);
      #1;
      if (done_o === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL aborted_run got dones=%0d busy=%b exp 0,0", dones, busy_o);
    end
    do_run(2, 2, 2, 1'b0);
    checks++;
    if ({g_acc[0][0], g_acc[0][1], g_acc[1][0], g_acc[1][1]} !== {32'd19, 32'd22, 32'd43, 32'd50}) begin
      errors++; $display("FAIL c_after_reset got=%0d,%0d,%0d,%0d exp=19,22,43,50", g_acc[0][0], g_acc[0][1], g_acc[1][0], g_acc[1][1]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_err();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_feed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_feed_ctrl.md
MATMUL_FEED_CTRL -- requirements
Module: matmul_feed_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, element width in bits.
REQ-002 Parameter BUS_WIDTH, default 64, bus width in bits.
REQ-003 Parameter MAX_DIM, default BUS_WIDTH/DATA_WIDTH, systolic array side length.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  request to start one multiplication; sampled only in IDLE.
REQ-007 n_i, k_i, m_i  in  2 each  actual dimensions; A is NxK, B is KxM; legal range 1..MAX_DIM.
REQ-008 operand_a_i  in  MAX_DIM*MAX_DIM*DATA_WIDTH  A, row-major; element [r][c] at offset (r*MAX_DIM+c)*DATA_WIDTH.
REQ-009 operand_b_i  in  MAX_DIM*MAX_DIM*DATA_WIDTH  B, same packing as A.
REQ-010 a_edge_o  out  MAX_DIM*DATA_WIDTH  left-edge feed; slot i drives array row i.
REQ-011 b_edge_o  out  MAX_DIM*DATA_WIDTH  top-edge feed; slot j drives array column j.
REQ-012 pe_clear_o  out  1  synchronous clear of all PE accumulators and pipeline registers.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 done_o  out  1  one-cycle pulse: c_matrix results are final.
REQ-015 err_o  out  1  one-cycle pulse: start rejected due to illegal dimensions.

Function
REQ-016 FSM states: IDLE, LOAD, FEED, DRAIN, DONE; state register and all outputs are registered.
REQ-017 IDLE: start_i=1 with all dims legal -> LOAD, capture operands and dims into internal registers.
REQ-018 IDLE: start_i=1 with any dim 0 or >MAX_DIM -> stay IDLE, pulse err_o next cycle, no capture.
REQ-019 start_i outside IDLE is ignored; input changes after capture do not affect the run.
REQ-020 LOAD lasts exactly 1 cycle with pe_clear_o=1 and edges zero; then FEED with t=0.
REQ-021 FEED: counter t runs 0..T_LAST, T_LAST=K+N+M-3 (captured dims); one value per cycle.
REQ-022 At FEED step t: a_edge slot i = A[i][t-i] if i<N and 0<=t-i<K, else 0.
REQ-023 At FEED step t: b_edge slot j = B[t-j][j] if j<M and 0<=t-j<K, else 0.
REQ-024 When t=T_LAST -> DRAIN; DRAIN lasts 1 cycle with edges zero; then DONE.
REQ-025 DONE lasts 1 cycle with done_o=1, edges zero; then IDLE.
REQ-026 Total latency: start sampled at edge e0 -> done_o high in the cycle after edge e0+K+N+M.
REQ-027 N=K=M=1 boundary: T_LAST=0; FEED lasts exactly one cycle.
REQ-028 Edges are zero in every state except FEED; unused slots (i>=N, j>=M) are always zero.
REQ-029 Counter width: at least clog2(3*MAX_DIM) bits; no wrap-around within a run.

Reset
REQ-030 rst_ni=0 forces state IDLE, t=0, captured registers 0, all outputs 0, without waiting for a clock.
REQ-031 Reset during any non-IDLE state aborts the run; no done_o is produced; next start runs normally.

Structure
REQ-032 DATA_WIDTH, BUS_WIDTH, MAX_DIM defaults and the state encoding constants live in the shared matmul package.
REQ-033 Single module; no sub-module; instantiated beside the PE grid and drives the grid's left/top edges and clear.

Verification (MAX_DIM=2, DATA_WIDTH=32, PE grid attached)
REQ-034 A=[[1,2],[3,4]], B=[[5,6],[7,8]], N=K=M=2 -> FEED 4 cycles, a_edge per t: (1,0),(2,3),(0,4),(0,0); done_o 6 cycles after start; C=[[19,22],[43,50]].
REQ-035 N=K=M=1, A[0][0]=7, B[0][0]=9 -> FEED 1 cycle, done_o 3 cycles after start, C[0][0]=63, other slots 0.
REQ-036 N=2,K=1,M=2, A col=(2,3), B row=(4,5) -> C=[[8,10],[12,15]], T_LAST=2.
REQ-037 start with k_i=0 -> err_o pulse, busy_o stays 0, no pe_clear_o.
REQ-038 start repeated during FEED -> ignored; exactly one done_o; back-to-back start after DONE runs a second matrix pair correctly with accumulators cleared.
REQ-039 rst_ni low mid-FEED -> outputs 0 immediately, no done_o; subsequent run of REQ-034 yields same C.
